// File: rtl/m_unit_issue_ctrl_pkg.sv
// rtl/m_unit_issue_ctrl_pkg.sv - shared types and constants for the M-unit issue sequencer
package m_issue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        DONE
    } state_t;

    localparam logic [6:0] OPC_OP          = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV   = 7'b0000001;
    localparam int         TIMEOUT_DEFAULT = 64;

    // An R-type op with the MULDIV funct7 is handled by the M unit
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/m_unit_issue_ctrl_if.sv
// rtl/m_unit_issue_ctrl_if.sv - EX/WB and M-unit signal bundle for the issue sequencer
interface m_unit_issue_ctrl_if;

    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd_addr;
    logic        flush;
    logic        wb_ready;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd_addr;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_wr;
    logic [31:0] m_rd;
    logic        m_busy;
    logic        m_ready;
    logic        timeout_err;

    modport master (
        input  ex_valid, ex_instr, ex_rs1, ex_rs2, ex_rd_addr, flush, wb_ready,
        input  m_wr, m_rd, m_busy, m_ready,
        output stall, res_valid, res_data, res_rd_addr,
        output m_valid, m_instr, m_rs1, m_rs2, timeout_err
    );

    modport slave (
        output ex_valid, ex_instr, ex_rs1, ex_rs2, ex_rd_addr, flush, wb_ready,
        output m_wr, m_rd, m_busy, m_ready,
        input  stall, res_valid, res_data, res_rd_addr,
        input  m_valid, m_instr, m_rs1, m_rs2, timeout_err
    );

endinterface

// File: rtl/m_unit_issue_ctrl_decode.sv
// rtl/m_unit_issue_ctrl_decode.sv - combinational M-extension op detect
module m_issue_decode
    import m_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_m
);

    // funct3 and register fields do not affect routing to the M unit
    logic unused_fields;
    assign unused_fields = ^instr[24:7];

    assign is_m = is_muldiv(instr[6:0], instr[31:25]);

endmodule

// File: rtl/m_unit_issue_ctrl.sv
// rtl/m_unit_issue_ctrl.sv - EX-to-M-unit issue sequencer with flush drain and hang timeout
module m_unit_issue_ctrl
    import m_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    m_unit_issue_ctrl_if.master bus
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             m_valid_q;
    logic             res_valid_q;
    logic             timeout_q;
    logic [31:0]      instr_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [4:0]       rd_q;
    logic [31:0]      res_data_q;
    logic [4:0]       res_rd_q;
    logic             is_m;
    logic             launch;
    logic             stall_c;

    // Busy is informational; completion is signalled solely by m_ready
    logic unused_busy;
    assign unused_busy = bus.m_busy;

    m_issue_decode u_decode (
        .instr (bus.ex_instr),
        .is_m  (is_m)
    );

    assign launch = bus.ex_valid & is_m & ~bus.flush;

    // Pipeline freeze: immediate on launch, held while waiting, released by writeback
    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:    stall_c = launch;
            BUSY:    stall_c = 1'b1;
            DRAIN:   stall_c = launch;
            DONE:    stall_c = ~bus.wb_ready;
            default: stall_c = 1'b0;
        endcase
    end

    // Issue FSM, timeout counter and result buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            m_valid_q   <= 1'b0;
            res_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        instr_q   <= bus.ex_instr;
                        rs1_q     <= bus.ex_rs1;
                        rs2_q     <= bus.ex_rs2;
                        rd_q      <= bus.ex_rd_addr;
                        cnt       <= '0;
                        m_valid_q <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (bus.flush || !bus.m_wr) begin
                            state <= IDLE;
                        end else begin
                            res_data_q  <= bus.m_rd;
                            res_rd_q    <= rd_q;
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (bus.flush) begin
                        // Unit cannot abort; keep the request up and discard its answer
                        cnt   <= '0;
                        state <= DRAIN;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.flush || bus.wb_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall       = stall_c & ~reset;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_instr     = instr_q;
    assign bus.m_rs1       = rs1_q;
    assign bus.m_rs2       = rs2_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd_addr = res_rd_q;
    assign bus.timeout_err = timeout_q;

    // The unit only answers an outstanding request
    a_ready_in_flight: assert property (@(posedge clk) disable iff (reset)
        bus.m_ready |-> (state == BUSY || state == DRAIN));

    // Completion is a one-cycle pulse
    a_ready_pulse: assert property (@(posedge clk) disable iff (reset)
        bus.m_ready |=> !bus.m_ready);

endmodule
